score_accum: RTL and testbench

//   Parametrised per-frame score/combo engine for the rhythm game. Samples per-lane
//   hit/miss counts on each frame_clk rising edge, applies a combo multiplier, and

---
 rtl/score_pkg.sv | 22 ++
 rtl/score_accum_if.sv | 39 +++
 rtl/score_lane_sum.sv | 20 ++
 rtl/score_accum.sv | 142 ++++++++++++++
 tb/tb_score_accum.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_pkg.sv
// Shared defaults, typedefs and width helpers for the rhythm-game score engine.
package score_pkg;

  localparam int DEF_NUM_LANES  = 4;
  localparam int DEF_CNT_W      = 4;
  localparam int DEF_SCORE_W    = 16;
  localparam int DEF_COMBO_W    = 10;
  localparam int HIT_PTS_DEF    = 1;
  localparam int MISS_PTS_DEF   = 1;
  localparam int COMBO_STEP_DEF = 8;
  localparam int MAX_MULT_DEF   = 4;

  typedef logic [DEF_CNT_W-1:0]   lane_cnt_t;
  typedef logic [DEF_SCORE_W-1:0] score_t;
  typedef logic [DEF_COMBO_W-1:0] combo_t;

  // One spare bit above the worst-case lane total.
  function automatic int sum_width(input int num_lanes, input int cnt_w);
    return cnt_w + $clog2(num_lanes) + 1;
  endfunction

endpackage

// File: rtl/score_accum_if.sv
// Judge-side inputs and HUD-side outputs of score_accum.
// SCORE_MAX_COMBO_EN adds the peak-combo output.
interface score_accum_if
  import score_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SCORE_W   = DEF_SCORE_W,
  parameter int COMBO_W   = DEF_COMBO_W,
  parameter int MAX_MULT  = MAX_MULT_DEF
);

  localparam int MULT_W = $clog2(MAX_MULT + 1);

  logic                       frame_clk;
  logic                       enable;
  logic                       clear;
  logic [NUM_LANES*CNT_W-1:0] hit;
  logic [NUM_LANES*CNT_W-1:0] miss;
  logic [SCORE_W-1:0]         score;
  logic [COMBO_W-1:0]         combo;
  logic [MULT_W-1:0]          mult;
  logic                       score_valid;

`ifdef SCORE_MAX_COMBO_EN
  logic [COMBO_W-1:0]         max_combo;

  modport master (output frame_clk, enable, clear, hit, miss,
                  input  score, combo, mult, score_valid, max_combo);
  modport slave  (input  frame_clk, enable, clear, hit, miss,
                  output score, combo, mult, score_valid, max_combo);
`else
  modport master (output frame_clk, enable, clear, hit, miss,
                  input  score, combo, mult, score_valid);
  modport slave  (input  frame_clk, enable, clear, hit, miss,
                  output score, combo, mult, score_valid);
`endif

endinterface

// File: rtl/score_lane_sum.sv
// Reduces packed per-lane counts (lane0 in the LSBs) to a single total.
module score_lane_sum
  import score_pkg::*;
#(
  parameter int NUM_LANES = DEF_NUM_LANES,
  parameter int CNT_W     = DEF_CNT_W,
  parameter int SUM_W     = sum_width(NUM_LANES, CNT_W)
) (
  input  logic [NUM_LANES*CNT_W-1:0] cnt,
  output logic [SUM_W-1:0]           sum
);

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sum = sum + SUM_W'(cnt[i*CNT_W +: CNT_W]);
    end
  end

endmodule

// File: rtl/score_accum.sv
// Per-frame score/combo engine: two-stage pipeline from frame tick to score update.
// SCORE_MAX_COMBO_EN enables peak-combo tracking on bus.max_combo.
module score_accum
  import score_pkg::*;
#(
  parameter int NUM_LANES  = DEF_NUM_LANES,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int SCORE_W    = DEF_SCORE_W,
  parameter int COMBO_W    = DEF_COMBO_W,
  parameter int HIT_PTS    = HIT_PTS_DEF,
  parameter int MISS_PTS   = MISS_PTS_DEF,
  parameter int COMBO_STEP = COMBO_STEP_DEF,
  parameter int MAX_MULT   = MAX_MULT_DEF
) (
  input logic          Clk,
  input logic          reset_n,
  score_accum_if.slave bus
);

  localparam int SUM_W  = sum_width(NUM_LANES, CNT_W);
  localparam int MULT_W = $clog2(MAX_MULT + 1);
  localparam int CW     = SCORE_W + 8;
  localparam int CSW    = ((COMBO_W > SUM_W) ? COMBO_W : SUM_W) + 1;
  localparam logic signed [CW-1:0] SCORE_CEIL = CW'({SCORE_W{1'b1}});
  localparam logic [COMBO_W-1:0]   COMBO_MAX  = '1;

  logic               frame_clk_q;
  logic               tick;
  logic [SUM_W-1:0]   hit_sum, miss_sum;
  logic [SUM_W-1:0]   hit_sum_q, miss_sum_q;
  logic               any_miss_q;
  logic               s1_valid;
  logic [SCORE_W-1:0] score_q, score_nxt;
  logic [COMBO_W-1:0] combo_q, combo_nxt;
  logic [MULT_W-1:0]  mult_q, mult_nxt;
  logic               score_valid_q;
  logic [CW-1:0]      gain, pen;
  logic signed [CW-1:0] acc;
  logic [CSW-1:0]     combo_sum;
  logic [COMBO_W-1:0] combo_steps;
  logic [COMBO_W:0]   mult_raw;

  assign tick = bus.frame_clk & ~frame_clk_q & bus.enable;

  score_lane_sum #(.NUM_LANES(NUM_LANES), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_hit_sum (
    .cnt (bus.hit),
    .sum (hit_sum)
  );

  score_lane_sum #(.NUM_LANES(NUM_LANES), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_miss_sum (
    .cnt (bus.miss),
    .sum (miss_sum)
  );

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_clk_q <= 1'b0;
      s1_valid    <= 1'b0;
      hit_sum_q   <= '0;
      miss_sum_q  <= '0;
      any_miss_q  <= 1'b0;
    end else begin
      frame_clk_q <= bus.frame_clk;
      s1_valid    <= tick & ~bus.clear;
      if (tick) begin
        hit_sum_q  <= hit_sum;
        miss_sum_q <= miss_sum;
        any_miss_q <= (miss_sum != '0);
      end
    end
  end

  // Gain uses the multiplier earned before this frame's combo update.
  always_comb begin
    gain = CW'(hit_sum_q) * CW'(HIT_PTS) * CW'(mult_q);
    pen  = CW'(miss_sum_q) * CW'(MISS_PTS);
    acc  = $signed(CW'(score_q)) + $signed(gain) - $signed(pen);
    if (acc[CW-1])
      score_nxt = '0;
    else if (acc > SCORE_CEIL)
      score_nxt = '1;
    else
      score_nxt = acc[SCORE_W-1:0];

    combo_sum = CSW'(combo_q) + CSW'(hit_sum_q);
    if (any_miss_q)
      combo_nxt = '0;
    else if (combo_sum > CSW'(COMBO_MAX))
      combo_nxt = COMBO_MAX;
    else
      combo_nxt = combo_sum[COMBO_W-1:0];

    combo_steps = combo_nxt / COMBO_W'(COMBO_STEP);
    mult_raw    = (COMBO_W+1)'(combo_steps) + (COMBO_W+1)'(1);
    if (mult_raw >= (COMBO_W+1)'(MAX_MULT))
      mult_nxt = MULT_W'(MAX_MULT);
    else
      mult_nxt = MULT_W'(mult_raw);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      score_q       <= '0;
      combo_q       <= '0;
      mult_q        <= MULT_W'(1);
      score_valid_q <= 1'b0;
    end else if (bus.clear) begin
      score_q       <= '0;
      combo_q       <= '0;
      mult_q        <= MULT_W'(1);
      score_valid_q <= 1'b0;
    end else begin
      score_valid_q <= s1_valid;
      if (s1_valid) begin
        score_q <= score_nxt;
        combo_q <= combo_nxt;
        mult_q  <= mult_nxt;
      end
    end
  end

`ifdef SCORE_MAX_COMBO_EN
  logic [COMBO_W-1:0] max_combo_q;

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n)
      max_combo_q <= '0;
    else if (bus.clear)
      max_combo_q <= '0;
    else if (s1_valid && (combo_nxt > max_combo_q))
      max_combo_q <= combo_nxt;
  end

  assign bus.max_combo = max_combo_q;
`endif

  assign bus.score       = score_q;
  assign bus.combo       = combo_q;
  assign bus.mult        = mult_q;
  assign bus.score_valid = score_valid_q;

endmodule

// File: tb/tb_score_accum.sv
// Scoreboard bench for score_accum: a frame-level reference model queues expected
// updates; a negedge monitor matches them against score_valid pulses.
module tb_score_accum;
  import score_pkg::*;

  localparam int NL         = 4;
  localparam int CNT_W      = 4;
  localparam int SCORE_W    = 16;
  localparam int COMBO_W    = 10;
  localparam int COMBO_STEP = 8;
  localparam int MAX_MULT   = 4;
  localparam int SCORE_TOP  = (1 << SCORE_W) - 1;
  localparam int COMBO_TOP  = (1 << COMBO_W) - 1;

  typedef struct {
    int     score;
    int     combo;
    int     mult;
    int     peak;
    longint cyc;
  } exp_t;

  logic   Clk = 1'b0;
  logic   reset_n = 1'b0;
  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;
  exp_t   exp_q[$];
  exp_t   mon_e;
  int     hl[NL];
  int     ml[NL];
  int     m_score, m_combo, m_peak;

  score_accum_if #(.NUM_LANES(NL), .CNT_W(CNT_W), .SCORE_W(SCORE_W),
                   .COMBO_W(COMBO_W), .MAX_MULT(MAX_MULT)) bus ();

  score_accum #(.NUM_LANES(NL), .CNT_W(CNT_W), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W),
                .HIT_PTS(1), .MISS_PTS(1), .COMBO_STEP(COMBO_STEP),
                .MAX_MULT(MAX_MULT)) dut (
    .Clk     (Clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint expv);
    n_checks++;
    if (act != expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic int mult_of(input int c);
    int m;
    m = 1 + c / COMBO_STEP;
    return (m > MAX_MULT) ? MAX_MULT : m;
  endfunction

  task automatic model_reset();
    m_score = 0;
    m_combo = 0;
    m_peak  = 0;
  endtask

  // Frame-level rules: score moves by hits*mult - misses, clamped; any miss breaks combo.
  task automatic model_tick();
    int   hs, ms;
    exp_t e;
    hs = 0;
    ms = 0;
    foreach (hl[i]) hs += hl[i];
    foreach (ml[i]) ms += ml[i];
    m_score = m_score + hs * mult_of(m_combo) - ms;
    if (m_score < 0) m_score = 0;
    if (m_score > SCORE_TOP) m_score = SCORE_TOP;
    m_combo = (ms != 0) ? 0 : ((m_combo + hs > COMBO_TOP) ? COMBO_TOP : m_combo + hs);
    if (m_combo > m_peak) m_peak = m_combo;
    e.score = m_score;
    e.combo = m_combo;
    e.mult  = mult_of(m_combo);
    e.peak  = m_peak;
    e.cyc   = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic set_lanes(input int h0, h1, h2, h3, m0, m1, m2, m3);
    hl = '{h0, h1, h2, h3};
    ml = '{m0, m1, m2, m3};
  endtask

  // Called on a negedge; frame strobe high for one cycle, then 'gap' idle cycles.
  task automatic do_tick(input bit en = 1, input bit drop_en = 0,
                         input bit clear_next = 0, input int gap = 2);
    for (int i = 0; i < NL; i++) begin
      bus.hit[i*CNT_W +: CNT_W]  = CNT_W'(hl[i]);
      bus.miss[i*CNT_W +: CNT_W] = CNT_W'(ml[i]);
    end
    bus.enable    = en;
    bus.frame_clk = 1'b1;
    if (en) model_tick();
    @(negedge Clk);
    bus.frame_clk = 1'b0;
    bus.hit       = '0;
    bus.miss      = '0;
    if (drop_en) bus.enable = 1'b0;
    if (clear_next) begin
      bus.clear = 1'b1;
      exp_q.delete(exp_q.size() - 1);
      model_reset();
      @(negedge Clk);
      bus.clear = 1'b0;
    end
    repeat (gap) @(negedge Clk);
    bus.enable = 1'b1;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    model_reset();
    @(negedge Clk);
    bus.clear = 1'b0;
  endtask

  always @(negedge Clk) begin
    if (reset_n) begin
      if (bus.score_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_score_valid", bus.score_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("latency", cyc, mon_e.cyc);
          chk("score", bus.score, mon_e.score);
          chk("combo", bus.combo, mon_e.combo);
          chk("mult", bus.mult, mon_e.mult);
`ifdef SCORE_MAX_COMBO_EN
          chk("max_combo", bus.max_combo, mon_e.peak);
`endif
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("missing_score_valid", bus.score_valid, 1);
        exp_q.delete(0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.frame_clk = 1'b0;
    bus.enable    = 1'b1;
    bus.clear     = 1'b0;
    bus.hit       = '0;
    bus.miss      = '0;
    model_reset();
    repeat (3) @(negedge Clk);
    reset_n = 1'b1;
    @(negedge Clk);
    chk("reset_score", bus.score, 0);
    chk("reset_combo", bus.combo, 0);
    chk("reset_mult", bus.mult, 1);
    chk("reset_valid", bus.score_valid, 0);

    set_lanes(1, 1, 1, 1, 0, 0, 0, 0);
    do_tick();
    chk("t2_score", bus.score, 4);
    chk("t2_combo", bus.combo, 4);

    do_clear();
    set_lanes(0, 0, 0, 0, 0, 0, 3, 0);
    do_tick();
    chk("t3_low_clamp", bus.score, 0);
    chk("t3_combo", bus.combo, 0);

    do_clear();
    set_lanes(10, 0, 0, 0, 0, 5, 0, 0);
    do_tick();
    set_lanes(5, 0, 0, 0, 0, 0, 0, 0);
    do_tick();
    set_lanes(3, 0, 0, 0, 0, 0, 0, 0);
    do_tick();
    chk("t4_score_a", bus.score, 13);
    chk("t4_combo_a", bus.combo, 8);
    chk("t4_mult_a", bus.mult, 2);
    set_lanes(0, 1, 0, 0, 0, 0, 0, 0);
    do_tick();
    chk("t4_score_b", bus.score, 15);
    chk("t4_combo_b", bus.combo, 9);

    do_clear();
    set_lanes(10, 0, 0, 0, 0, 5, 0, 0);
    do_tick();
    set_lanes(5, 0, 0, 0, 0, 0, 0, 0);
    do_tick();
    set_lanes(2, 0, 0, 0, 0, 1, 0, 0);
    do_tick();
    chk("t5_score", bus.score, 11);
    chk("t5_combo", bus.combo, 0);
    chk("t5_mult", bus.mult, 1);

    // Clear one cycle after a tick flushes that frame.
    set_lanes(7, 0, 0, 0, 0, 0, 0, 0);
    do_tick(1, 0, 1);
    chk("inflight_clear_score", bus.score, 0);

    // Dropping enable after the tick must not lose the frame; a disabled tick is ignored.
    set_lanes(3, 3, 0, 0, 0, 0, 0, 0);
    do_tick(1, 1);
    chk("enable_drop_score", bus.score, 6);
    set_lanes(9, 9, 9, 9, 0, 0, 0, 0);
    do_tick(0);
    chk("disabled_tick_score", bus.score, m_score);

    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < NL; i++) begin
        hl[i] = $urandom_range(0, 15);
        ml[i] = 0;
      end
      if ($urandom_range(0, 3) == 0) ml[$urandom_range(0, NL - 1)] = $urandom_range(1, 15);
      do_tick($urandom_range(0, 7) != 0, 0, 0, $urandom_range(2, 4));
      if ($urandom_range(0, 15) == 0) do_clear();
    end
    chk("random_end_score", bus.score, m_score);

    // Build mult=4 then climb to exactly 65534, pushing combo into saturation.
    do_clear();
    set_lanes(15, 11, 0, 0, 0, 0, 0, 0);
    do_tick();
    set_lanes(15, 15, 15, 15, 0, 0, 0, 0);
    for (int n = 0; n < 272; n++) do_tick();
    set_lanes(15, 15, 15, 12, 0, 0, 0, 0);
    do_tick();
    chk("t6_score_pre", bus.score, 65534);
    chk("t6_mult_pre", bus.mult, 4);
    chk("t6_combo_sat", bus.combo, COMBO_TOP);
    set_lanes(0, 0, 0, 2, 0, 0, 0, 0);
    do_tick();
    chk("t6_high_clamp", bus.score, 65535);

    // Reset one cycle after a tick: the in-flight frame must never report.
    set_lanes(0, 5, 0, 0, 0, 0, 0, 0);
    bus.hit[CNT_W +: CNT_W] = CNT_W'(hl[1]);
    bus.frame_clk = 1'b1;
    @(posedge Clk);
    #1;
    reset_n       = 1'b0;
    bus.frame_clk = 1'b0;
    bus.hit       = '0;
    exp_q.delete();
    model_reset();
    @(negedge Clk);
    @(negedge Clk);
    reset_n = 1'b1;
    repeat (6) @(negedge Clk);
    chk("t6_reset_score", bus.score, 0);
    chk("t6_reset_combo", bus.combo, 0);
    chk("t6_reset_mult", bus.mult, 1);
`ifdef SCORE_MAX_COMBO_EN
    chk("t6_reset_peak", bus.max_combo, 0);
`endif

    repeat (5) @(negedge Clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
